// File: rtl/hd44780_pkg.sv
// Shared HD44780 definitions: opcodes, DDRAM constants, FSM encoding, address helper.
package hd44780_pkg;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPCTL = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNC    = 8'h20;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  localparam logic [6:0] LINE2_BASE  = 7'h40;
  localparam logic [7:0] SPACE       = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEARING,
    ST_BUSY
  } state_t;

  // Step a DDRAM address one position; line ends wrap onto the other line.
  function automatic logic [6:0] next_addr(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      if (a == 7'h0F)             r = LINE2_BASE;
      else if (a == 7'h4F)        r = 7'h00;
      else                        r = a + 7'd1;
    end else begin
      if (a == 7'h00)             r = 7'h4F;
      else if (a == LINE2_BASE)   r = 7'h0F;
      else                        r = a - 7'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hd44780_ddram.sv
// 32x8 DDRAM mirror: synchronous write port A, registered read port B (read-before-write).
module hd44780_ddram (
  input  logic       clk,
  input  logic       i_we_a,
  input  logic [4:0] i_addr_a,
  input  logic [7:0] i_wdata_a,
  input  logic [4:0] i_addr_b,
  output logic [7:0] o_rdata_b
);

  logic [7:0] r_mem [32];
  logic [7:0] r_rdata;

  // Port A write
  always_ff @(posedge clk) begin
    if (i_we_a) r_mem[i_addr_a] <= i_wdata_a;
  end

  // Port B registered read; a colliding write is seen on the next read
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_addr_b];
  end

  assign o_rdata_b = r_rdata;

endmodule

// File: rtl/hd44780_responder.sv
// HD44780-compatible bus responder: samples the writer's strobe, decodes
// commands/data, keeps a 2x16 DDRAM mirror plus cursor and mode state.
module hd44780_responder
  import hd44780_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int NUM_COLS     = 16,
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lcd_rs,
  input  logic                 lcd_rw,
  input  logic                 lcd_en,
  input  logic [DATA_BITS-1:0] lcd_data_in,
  output logic [DATA_BITS-1:0] lcd_data_out,
  output logic                 lcd_data_oe,
  input  logic [4:0]           rd_addr,
  output logic [7:0]           rd_char,
  output logic [6:0]           cursor_addr,
  output logic                 busy,
  output logic                 display_on,
  output logic                 cursor_on,
  output logic                 blink_on,
  output logic                 two_line,
  output logic                 incr_mode,
  output logic                 err_pulse
);

  localparam int MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int FILL_N = 2 * NUM_COLS;
  localparam logic [4:0] FILL_LAST = 5'(FILL_N - 1);

  logic [SYNC_STAGES-1:0] r_en_sync;
  logic                   r_en_d;
  logic                   r_rs, r_rw;
  logic [DATA_BITS-1:0]   r_data;
  logic                   w_en_s, w_fall;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [4:0]             r_fill;
  logic [6:0]             r_addr;
  logic                   r_disp, r_curs, r_blink, r_two, r_inc, r_err;
  logic                   r_cmd_rs;
  logic [7:0]             r_cmd;

  logic                   w_we;
  logic [4:0]             w_waddr;
  logic [7:0]             w_wdata;

  // Strobe synchronizer, edge history and per-cycle capture of rs/rw/data
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_en_sync <= '0;
      r_en_d    <= 1'b0;
      r_rs      <= 1'b0;
      r_rw      <= 1'b0;
      r_data    <= '0;
    end else begin
      r_en_sync <= {r_en_sync[SYNC_STAGES-2:0], lcd_en};
      r_en_d    <= w_en_s;
      r_rs      <= lcd_rs;
      r_rw      <= lcd_rw;
      r_data    <= lcd_data_in;
    end
  end

  assign w_en_s = r_en_sync[SYNC_STAGES-1];
  assign w_fall = r_en_d & ~w_en_s;

  // Access FSM: capture in IDLE, apply in EXEC, fill in CLEARING, time out in BUSY
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_fill   <= '0;
      r_addr   <= 7'h00;
      r_disp   <= 1'b0;
      r_curs   <= 1'b0;
      r_blink  <= 1'b0;
      r_two    <= 1'b0;
      r_inc    <= 1'b1;
      r_err    <= 1'b0;
      r_cmd_rs <= 1'b0;
      r_cmd    <= 8'h00;
    end else begin
      r_err <= 1'b0;
      // Data reads are unsupported; writes arriving while busy are dropped
      if (w_fall && r_rw && r_rs)                     r_err <= 1'b1;
      if (w_fall && !r_rw && (r_state != ST_IDLE))    r_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_fall && !r_rw) begin
            r_cmd_rs <= r_rs;
            r_cmd    <= 8'(r_data);
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state <= ST_BUSY;
          r_cnt   <= CW'(BUSY_CYCLES - 1);
          if (r_cmd_rs) begin
            r_addr <= next_addr(r_addr, r_inc);
          end else if ((r_cmd & CMD_DDRAM) != 8'h00) begin
            r_addr <= {r_cmd[6], 2'b00, r_cmd[3:0]};
          end else if ((r_cmd & CMD_CGRAM) != 8'h00) begin
            r_err <= 1'b1;
          end else if ((r_cmd & CMD_FUNC) != 8'h00) begin
            r_two <= r_cmd[3];
            if (!r_cmd[4]) r_err <= 1'b1;
          end else if ((r_cmd & CMD_SHIFT) != 8'h00) begin
            if (r_cmd[3]) r_err  <= 1'b1;
            else          r_addr <= next_addr(r_addr, r_cmd[2]);
          end else if ((r_cmd & CMD_DISPCTL) != 8'h00) begin
            r_disp  <= r_cmd[2];
            r_curs  <= r_cmd[1];
            r_blink <= r_cmd[0];
          end else if ((r_cmd & CMD_ENTRY) != 8'h00) begin
            r_inc <= r_cmd[1];
            if (r_cmd[0]) r_err <= 1'b1;
          end else if ((r_cmd & CMD_HOME) != 8'h00) begin
            r_addr <= 7'h00;
            r_cnt  <= CW'(CLEAR_CYCLES - 1);
          end else if ((r_cmd & CMD_CLEAR) != 8'h00) begin
            r_addr  <= 7'h00;
            r_inc   <= 1'b1;
            r_fill  <= 5'd0;
            r_state <= ST_CLEARING;
          end
        end
        ST_CLEARING: begin
          r_fill <= r_fill + 5'd1;
          if (r_fill == FILL_LAST) begin
            r_state <= ST_BUSY;
            r_cnt   <= CW'(CLEAR_CYCLES - FILL_N - 1);
          end
        end
        ST_BUSY: begin
          // Counter value N keeps BUSY for N cycles, so EXEC+BUSY spans the full budget
          if (r_cnt <= CW'(1)) r_state <= ST_IDLE;
          else                 r_cnt   <= r_cnt - CW'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM write mux; gated by reset so an aborted clear leaves the rest untouched
  assign w_we    = reset && ((r_state == ST_CLEARING) || ((r_state == ST_EXEC) && r_cmd_rs));
  assign w_waddr = (r_state == ST_CLEARING) ? r_fill : {r_addr[6], r_addr[3:0]};
  assign w_wdata = (r_state == ST_CLEARING) ? SPACE : r_cmd;

  hd44780_ddram u_ddram (
    .clk       (clk),
    .i_we_a    (w_we),
    .i_addr_a  (w_waddr),
    .i_wdata_a (w_wdata),
    .i_addr_b  (rd_addr),
    .o_rdata_b (rd_char)
  );

  assign busy         = (r_state != ST_IDLE);
  assign lcd_data_oe  = w_en_s & r_rw;
  assign lcd_data_out = (lcd_data_oe && !r_rs) ? DATA_BITS'({busy, r_addr}) : '0;
  assign cursor_addr  = r_addr;
  assign display_on   = r_disp;
  assign cursor_on    = r_curs;
  assign blink_on     = r_blink;
  assign two_line     = r_two;
  assign incr_mode    = r_inc;
  assign err_pulse    = r_err;

endmodule

// File: doc/hd44780_responder.md
Name: hd44780_responder

Overview:
- Synthesizable HD44780-compatible display responder: the receiving end of the 8-bit parallel LCD bus driven by the team's LCD message writers.
- Samples rs/rw/en/data from the writer, decodes commands and characters, and keeps a 2x16 DDRAM mirror plus cursor and mode state.
- Provides a busy/status readback and a character read port, so a VGA or 7-segment mirror, or a self-checking bench, can show what the LCD would display.

Parameters:
- DATA_BITS, 8, bus width (only 8 supported).
- NUM_COLS, 16, visible columns per line (2 lines fixed).
- BUSY_CYCLES, 2000, clk cycles busy after a normal command or data write (40 us at 50 MHz).
- CLEAR_CYCLES, 82000, clk cycles busy after Clear/Return Home (1.64 ms); must be >= 2*NUM_COLS.
- SYNC_STAGES, 2, synchronizer depth on lcd_en.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-low.
- lcd_rs, input, 1, 0=command/status, 1=data.
- lcd_rw, input, 1, 0=write, 1=read.
- lcd_en, input, 1, strobe, asynchronous to clk.
- lcd_data_in, input, 8, bus from writer.
- lcd_data_out, output, 8, status byte for reads.
- lcd_data_oe, output, 1, drive enable for lcd_data_out.
- rd_addr, input, 5, {line, col[3:0]} mirror read address.
- rd_char, output, 8, DDRAM[rd_addr], registered, 1-cycle latency.
- cursor_addr, output, 7, current HD44780 DDRAM address.
- busy, output, 1, busy flag.
- display_on, output, 1, D bit.
- cursor_on, output, 1, C bit.
- blink_on, output, 1, B bit.
- two_line, output, 1, N bit.
- incr_mode, output, 1, I/D bit.
- err_pulse, output, 1, 1-cycle pulse on a dropped or unsupported access.

Behaviour:
- Reset (reset==0 at posedge clk): state IDLE; busy=0, cursor_addr=0x00, display_on=0, cursor_on=0, blink_on=0, two_line=0, incr_mode=1, lcd_data_oe=0, lcd_data_out=0x00, err_pulse=0, DDRAM not cleared. Reset mid-CLEARING or mid-BUSY aborts it immediately.
- Sampling:
  - lcd_en passes through SYNC_STAGES flops.
  - rs/rw/data are registered every cycle alongside the synchronized en.
  - Access = falling edge of synchronized en; use the rs/rw/data values registered in the cycle before the fall.
  - Latency from en fall at the pins to the EXEC state is SYNC_STAGES+1 cycles.
- Reads (rw=1):
  - lcd_data_oe=1 while synchronized en=1 and rw=1.
  - rs=0: lcd_data_out={busy, cursor_addr}.
  - rs=1: unsupported; drives 0x00 and pulses err_pulse at the falling edge.
  - Reads never set busy.
- FSM states IDLE, EXEC, CLEARING, BUSY:
  - IDLE -> EXEC on a write access.
  - EXEC, one cycle: apply the write. Then go to CLEARING for Clear, else BUSY with counter = BUSY_CYCLES-1 (Return Home: CLEAR_CYCLES-1).
  - CLEARING: write 0x20 to one DDRAM entry per cycle for 32 cycles. Then go to BUSY with counter = CLEAR_CYCLES-33.
  - BUSY: decrement the counter; at 0 go to IDLE.
  - busy=1 in EXEC, CLEARING and BUSY.
- A write access outside IDLE is dropped and pulses err_pulse; state and timer are unaffected.
- Command decode (rs=0), highest set bit wins:
  - 0x01 Clear: fill spaces, addr=0x00, incr_mode=1.
  - 0x02/0x03 Return Home: addr=0x00, DDRAM unchanged.
  - 0x04-0x07 Entry Mode: incr_mode=bit1. S bit (bit0)=1 is unsupported and pulses err_pulse.
  - 0x08-0x0F Display control: D=bit2, C=bit1, B=bit0.
  - 0x10-0x1F Cursor/Display shift: cursor shift moves addr by +/-1 using the wrap rules below; display shift pulses err_pulse with no other effect.
  - 0x20-0x3F Function Set: two_line=bit3. DL=0 (bit4) pulses err_pulse but N is still applied.
  - 0x40-0x7F Set CGRAM: ignored, err_pulse.
  - 0x80-0xFF Set DDRAM: addr={bit6, 2'b00, bits3:0}; bits5:4 ignored.
- Data write (rs=1):
  - DDRAM[{addr[6], addr[3:0]}] <= data.
  - Then the address moves.
- Address move:
  - incr_mode=1: 0x0F -> 0x40, 0x4F -> 0x00, else +1.
  - incr_mode=0: 0x00 -> 0x4F, 0x40 -> 0x0F, else -1.
  - Wrapping applies regardless of two_line.
- DDRAM is 32x8. rd_char reads port B and is independent of the FSM; a same-cycle write and read at the same address returns the old value.

Decomposition:
- Package hd44780_pkg holds:
  - command opcodes and masks (CLEAR 0x01, HOME 0x02, ENTRY 0x04, DISPCTL 0x08, SHIFT 0x10, FUNC 0x20, CGRAM 0x40, DDRAM 0x80);
  - LINE2_BASE 0x40 and SPACE 0x20;
  - FSM state encoding.
- The writers also use this package.
- One sub-module, hd44780_ddram: 32x8 dual-port RAM, sync write port A, registered read port B.

Test Plan:
- Reset, then write 0x38, 0x06, 0x0C, 0x01 with a 2-cycle en high between accesses and waiting for busy=0 after each -> two_line=1, display_on=1, cursor_on=0, incr_mode=1, all rd_char=0x20, cursor_addr=0x00; the last busy pulse lasts CLEAR_CYCLES.
- Write data 0x41 ("A") 16 times, then 0x42 -> DDRAM 0-15 hold 0x41, rd_addr=16 returns 0x42, cursor_addr=0x41 (line wrap).
- Write 0x04, then 0x80 (addr 0x00), then data 0x5A -> DDRAM[0]=0x5A, cursor_addr=0x4F (decrement wrap).
- Write 0x0C and, 100 cycles later, data 0x31 while busy -> second write dropped, err_pulse high for 1 cycle, DDRAM unchanged, busy ends exactly BUSY_CYCLES after the first EXEC.
- Status read: rw=1, rs=0 with en high during CLEARING -> lcd_data_oe=1, lcd_data_out[7]=1; repeat after idle at addr 0x45 -> 0x45.
- Assert reset mid-CLEARING at fill index 10 -> next cycle busy=0, state IDLE, entries 10-31 retain old contents.
